counter_sequencer: RTL and testbench
====================================

# counter_sequencer

Command-driven controller that sequences a WIDTH-bit up-counter, replacing the bare free-running counter on the tile's output pins. It accepts opcode/argument commands over a valid/ready handshake to start, stop, load, single-step, and run-to-target the counter. A programmable prescaler sets the count rate. Status pulses for completion and wrap go to the remaining output pins.

## Interface
- WIDTH, default 4: counter width in bits.
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command strobe; a command is accepted on a rising edge where cmd_valid && cmd_ready.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  3  opcode, sampled on acceptance.
- cmd_arg  input  8  argument, sampled on acceptance; LOAD/TARGET use cmd_arg[WIDTH-1:0].
- count  output  WIDTH  current counter value (registered).
- busy  output  1  high when state is not IDLE.
- done  output  1  one-cycle pulse when a TARGET run completes.
- wrap  output  1  one-cycle pulse on the edge where count advances from all-ones to zero.

## Operation
- States: IDLE, RUN, TARGET.
- Opcodes:
  - 0 NOP: no effect.
  - 1 STOP: go to IDLE; count held.
  - 2 RUN: go to RUN; prescaler cleared.
  - 3 LOAD: count <= arg. State unchanged; prescaler cleared.
  - 4 TARGET: tgt <= arg, go to TARGET, prescaler cleared.
  - 5 STEP: count <= count+1; state <= IDLE.
  - 6 SET_DIV: div <= cmd_arg[7:0]; prescaler cleared. State unchanged.
  - 7 CLEAR: count <= 0, div <= 0, state <= IDLE.
- Prescaler: 8-bit presc counts 0..div. Tick fires when presc == div, then presc returns to 0. With div = 0, a tick fires every cycle.
- RUN: count advances by 1 on each tick and wraps modulo 2^WIDTH.
- TARGET:
  - Count advances on ticks. On the tick where count+1 == tgt, count <= tgt, state <= IDLE, and done pulses on the same edge.
  - If count == tgt at acceptance, the state goes to IDLE on the next edge with done pulsed and count unchanged.
  - Always terminates within 2^WIDTH ticks because the counter wraps.
- cmd_ready = (state != TARGET). Commands are accepted in IDLE and RUN only.
- Holding cmd_valid through TARGET has no effect until cmd_ready returns high.
- wrap pulses on any advance from all-ones to zero: RUN, TARGET, or STEP.
- Arithmetic is unsigned, modulo 2^WIDTH. No saturation.

## Timing
- Reset values: count 0, state IDLE, div 0, presc 0, tgt 0, done 0, wrap 0, busy 0. cmd_ready is 1 (it is combinational from state).
- Reset is asynchronous and may occur mid-RUN or mid-TARGET. All registers clear immediately; no done pulse is generated.
- Command accepted at edge N: the register effect is visible after edge N.
  - RUN/TARGET first advance occurs at edge N+1+div.
  - LOAD/STEP/CLEAR values appear after edge N.
- done and wrap are registered and high for exactly one cycle.
- busy and cmd_ready are combinational from the state register. cmd_ready falls the cycle after TARGET is accepted and rises the cycle after done.
- LOAD during RUN restarts prescaler phase: next advance at N+1+div.
- SET_DIV during RUN takes effect with presc cleared at edge N.

## Structure
- Package counter_sequencer_pkg holds:
  - the op_e enum (3-bit opcodes above);
  - the state_e enum (IDLE, RUN, TARGET);
  - the localparam for the 8-bit prescaler width.
- Sub-module tick_prescaler contains the presc/div registers and exposes:
  - inputs clk, rst_n, clear, div_we, div_in[7:0];
  - output tick.
- The top module owns the FSM, count, tgt, and pulses. It is instantiated in the tile wrapper with count on uo_out[3:0], done/wrap/busy on uo_out[6:4], and the command fields on ui_in/uio_in.

## Test plan
- Reset: hold rst_n low 3 cycles → count=0, busy=0, done=0, wrap=0, cmd_ready=1.
- RUN with div=0 for 17 cycles → count steps 1..F then 0, wrap high exactly on the F→0 cycle. Then STOP → count frozen at 1, busy=0.
- SET_DIV 2, then RUN → count increments every 3 cycles: first increment 3 edges after acceptance. LOAD 7 mid-run → count=7, next increment 3 edges later.
- LOAD 5, TARGET 9 with cmd_valid held high → cmd_ready=0 for 4 ticks, count 6,7,8,9. done pulses with count=9, then busy=0 and cmd_ready=1. No extra command is accepted during TARGET.
- Boundary cases:
  - LOAD E, TARGET 2 → count E,F,0,1,2, wrap on F→0, done at 2.
  - TARGET equal to the current count → done next cycle, count unchanged.
- Reset asserted mid-TARGET (count=3, tgt=C) → outputs clear asynchronously, no done pulse. After release, STEP → count=1.

Source files
------------

// File: rtl/counter_sequencer_pkg.sv
// Shared types and widths for the command-driven counter sequencer.
package counter_sequencer_pkg;

    localparam int unsigned PRESC_W = 8;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned ARG_W   = 8;

    typedef enum logic [OP_W-1:0] {
        OP_NOP     = 3'd0,
        OP_STOP    = 3'd1,
        OP_RUN     = 3'd2,
        OP_LOAD    = 3'd3,
        OP_TARGET  = 3'd4,
        OP_STEP    = 3'd5,
        OP_SET_DIV = 3'd6,
        OP_CLEAR   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_TARGET = 2'd2
    } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Programmable rate divider: tick is high in the cycle where presc == div.
module tick_prescaler
    import counter_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               div_we,
    input  logic [PRESC_W-1:0] div_in,
    output logic               tick
);

    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_div;

    assign tick = (r_presc == r_div);

    // A divider write also restarts the phase so the new rate starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_div   <= '0;
        end else begin
            if (div_we) begin
                r_div <= div_in;
            end
            if (clear || div_we || tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PRESC_W'(1);
            end
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven up-counter with prescaled RUN/TARGET modes and done/wrap pulses.
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [ARG_W-1:0] cmd_arg,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    state_e             r_state;
    logic [WIDTH-1:0]   r_count;
    logic [WIDTH-1:0]   r_tgt;
    logic               r_done;
    logic               r_wrap;

    state_e             w_state_nxt;
    logic [WIDTH-1:0]   w_count_nxt;
    logic [WIDTH-1:0]   w_tgt_nxt;
    logic               w_done_nxt;
    logic               w_wrap_nxt;
    logic               w_presc_clr;
    logic               w_div_we;
    logic [PRESC_W-1:0] w_div_in;
    logic               w_tick;
    logic               w_accept;
    op_e                w_op;
    logic [WIDTH-1:0]   w_count_inc;
    logic [WIDTH-1:0]   w_arg;
    logic               w_all_ones;

    assign cmd_ready   = (r_state != ST_TARGET);
    assign busy        = (r_state != ST_IDLE);
    assign count       = r_count;
    assign done        = r_done;
    assign wrap        = r_wrap;

    assign w_accept    = cmd_valid && cmd_ready;
    assign w_op        = op_e'(cmd_op);
    assign w_arg       = cmd_arg[WIDTH-1:0];
    assign w_count_inc = r_count + WIDTH'(1);
    assign w_all_ones  = &r_count;

    tick_prescaler u_presc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_presc_clr),
        .div_we (w_div_we),
        .div_in (w_div_in),
        .tick   (w_tick)
    );

    // Next-state and datapath; an accepted non-NOP command owns this edge.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_tgt_nxt   = r_tgt;
        w_done_nxt  = 1'b0;
        w_wrap_nxt  = 1'b0;
        w_presc_clr = 1'b0;
        w_div_we    = 1'b0;
        w_div_in    = cmd_arg;

        if (w_accept && (w_op != OP_NOP)) begin
            case (w_op)
                OP_STOP: begin
                    w_state_nxt = ST_IDLE;
                end
                OP_RUN: begin
                    w_state_nxt = ST_RUN;
                    w_presc_clr = 1'b1;
                end
                OP_LOAD: begin
                    w_count_nxt = w_arg;
                    w_presc_clr = 1'b1;
                end
                OP_TARGET: begin
                    w_tgt_nxt   = w_arg;
                    w_state_nxt = ST_TARGET;
                    w_presc_clr = 1'b1;
                end
                OP_STEP: begin
                    w_count_nxt = w_count_inc;
                    w_wrap_nxt  = w_all_ones;
                    w_state_nxt = ST_IDLE;
                end
                OP_SET_DIV: begin
                    w_div_we = 1'b1;
                end
                OP_CLEAR: begin
                    w_count_nxt = '0;
                    w_div_we    = 1'b1;
                    w_div_in    = '0;
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                end
            endcase
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_tick) begin
                        w_count_nxt = w_count_inc;
                        w_wrap_nxt  = w_all_ones;
                    end
                end
                ST_TARGET: begin
                    // Target already reached at acceptance: finish without counting.
                    if (r_count == r_tgt) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else if (w_tick) begin
                        w_count_nxt = w_count_inc;
                        w_wrap_nxt  = w_all_ones;
                        if (w_count_inc == r_tgt) begin
                            w_state_nxt = ST_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_tgt   <= '0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_tgt   <= w_tgt_nxt;
            r_done  <= w_done_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed-vector bench for counter_sequencer with hand-computed expectations.
module tb_counter_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_arg;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       wrap;

    int n_vec;
    int n_miss;

    counter_sequencer #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one command for exactly one edge, then withdraw it.
    task automatic cmd(input logic [2:0] op, input logic [7:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        cyc();
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_arg   = 8'd0;
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_arg   = 8'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'h1);
        rst_n = 1'b1;
        cyc();

        // Free run at full rate through a wrap, then stop on count 1.
        cmd(3'd2, 8'd0);
        chk("run_start", 32'(count), 32'h0);
        chk("run_busy", 32'(busy), 32'h1);
        for (int i = 1; i <= 17; i++) begin
            cyc();
            chk("run_cnt", 32'(count), 32'(i % 16));
            chk("run_wrap", 32'(wrap), (i == 16) ? 32'h1 : 32'h0);
        end
        cmd(3'd1, 8'd0);
        chk("stop_cnt", 32'(count), 32'h1);
        chk("stop_busy", 32'(busy), 32'h0);
        cyc();
        cyc();
        chk("stop_hold", 32'(count), 32'h1);

        // Divide by 3, then LOAD mid-run restarts the phase.
        cmd(3'd6, 8'd2);
        cmd(3'd2, 8'd0);
        cyc(); chk("div_e1", 32'(count), 32'h1);
        cyc(); chk("div_e2", 32'(count), 32'h1);
        cyc(); chk("div_e3", 32'(count), 32'h2);
        cyc(); cyc();
        cyc(); chk("div_e6", 32'(count), 32'h3);
        cmd(3'd3, 8'd7);
        chk("ld_val", 32'(count), 32'h7);
        chk("ld_busy", 32'(busy), 32'h1);
        cyc(); chk("ld_e1", 32'(count), 32'h7);
        cyc(); chk("ld_e2", 32'(count), 32'h7);
        cyc(); chk("ld_e3", 32'(count), 32'h8);
        cmd(3'd1, 8'd0);
        cmd(3'd6, 8'd0);

        // TARGET 9 from 5 with a competing LOAD held on the bus throughout.
        cmd(3'd3, 8'd5);
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        cmd_arg   = 8'd9;
        cyc();
        cmd_op  = 3'd3;
        cmd_arg = 8'h0a;
        chk("tg_ready0", 32'(cmd_ready), 32'h0);
        chk("tg_busy", 32'(busy), 32'h1);
        chk("tg_c0", 32'(count), 32'h5);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk("tg_cnt", 32'(count), 32'(5 + i));
            chk("tg_ready", 32'(cmd_ready), 32'h0);
            chk("tg_done0", 32'(done), 32'h0);
        end
        cyc();
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_arg   = 8'd0;
        chk("tg_final", 32'(count), 32'h9);
        chk("tg_done", 32'(done), 32'h1);
        chk("tg_idle", 32'(busy), 32'h0);
        chk("tg_ready1", 32'(cmd_ready), 32'h1);
        cyc();
        chk("tg_done_pulse", 32'(done), 32'h0);
        chk("tg_hold", 32'(count), 32'h9);

        // TARGET across the wrap point.
        cmd(3'd3, 8'h0e);
        cmd(3'd4, 8'h02);
        chk("tw_c0", 32'(count), 32'he);
        cyc(); chk("tw_c1", 32'(count), 32'hf);
        cyc(); chk("tw_c2", 32'(count), 32'h0);
        chk("tw_wrap", 32'(wrap), 32'h1);
        cyc(); chk("tw_c3", 32'(count), 32'h1);
        chk("tw_wrap0", 32'(wrap), 32'h0);
        chk("tw_done0", 32'(done), 32'h0);
        cyc(); chk("tw_c4", 32'(count), 32'h2);
        chk("tw_done", 32'(done), 32'h1);

        // TARGET equal to current count finishes on the next edge.
        cmd(3'd4, 8'h02);
        chk("te_busy", 32'(busy), 32'h1);
        chk("te_done0", 32'(done), 32'h0);
        cyc();
        chk("te_done", 32'(done), 32'h1);
        chk("te_cnt", 32'(count), 32'h2);
        chk("te_idle", 32'(busy), 32'h0);

        // STEP wraps and pulses wrap; CLEAR resets count and divider.
        cmd(3'd3, 8'h0f);
        cmd(3'd5, 8'd0);
        chk("st_cnt", 32'(count), 32'h0);
        chk("st_wrap", 32'(wrap), 32'h1);
        cmd(3'd6, 8'd3);
        cmd(3'd3, 8'h06);
        cmd(3'd7, 8'd0);
        chk("clr_cnt", 32'(count), 32'h0);
        cmd(3'd2, 8'd0);
        cyc();
        chk("clr_div0", 32'(count), 32'h1);
        cmd(3'd1, 8'd0);

        // Asynchronous reset in the middle of a TARGET run.
        cmd(3'd3, 8'd3);
        cmd(3'd4, 8'h0c);
        chk("ar_pre_busy", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_cnt", 32'(count), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_ready", 32'(cmd_ready), 32'h1);
        chk("ar_done", 32'(done), 32'h0);
        cyc();
        cyc();
        chk("ar_done_hold", 32'(done), 32'h0);
        rst_n = 1'b1;
        cmd(3'd5, 8'd0);
        chk("ar_step", 32'(count), 32'h1);
        chk("ar_step_busy", 32'(busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
